mdu_iterative: RTL
==================

Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit for the MIPS datapath.
- The ALU handles the single-cycle ops; this block executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- The controller issues an op with a start pulse, then waits on busy/done.
- mfhi/mflo read hi/lo directly.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each; iteration count = WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  issue op; sampled only when busy=0
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
- a  input  WIDTH  rs operand (multiplicand/dividend/mthi-mtlo data)
- b  input  WIDTH  rt operand (multiplier/divisor)
- busy  output  1  iterative op in progress
- done  output  1  one-cycle pulse; hi/lo hold the new result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - All internal counters and accumulators are cleared.
  - Reset mid-operation aborts it; the result is never written.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op in {000..011}: latch magnitudes into the working registers, save both operand signs, counter=0, go to RUN. busy=1 from the next cycle.
  - Signed ops take |a| and |b|; unsigned ops use the raw values.
  - start=1 with op 100 or 101: write hi (or lo) = a at the edge; stay IDLE; no busy, no done.
  - start=1 with op 11x, or start=0: no effect.
- RUN: exactly WIDTH cycles, one iteration per cycle, counter 0..WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH product register.
  - Divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
  - At counter=WIDTH-1, go to FIX.
- FIX: one cycle of sign fix-up.
  - Signed multiply: product negated (2*WIDTH two's complement) if the signs differ.
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign.
  - At the FIX->IDLE edge: {hi,lo} = product, or hi=remainder, lo=quotient. done=1 for exactly the next cycle; busy=0 in that same cycle.
- Latency:
  - start sampled at edge E0; busy high after E0 through E0+WIDTH+1.
  - hi/lo update at E0+WIDTH+1 (edge 33 for WIDTH=32); done high in the following cycle.
- Handshake:
  - start while busy=1 is ignored (op dropped, no queuing).
  - start in the done cycle is accepted (busy already 0).
- hi/lo hold their old values during RUN/FIX; mfhi reads mid-operation return the old values.
- Divide by zero (b=0):
  - Completes with the full normal latency.
  - hi = a (raw dividend, unmodified), lo = all ones; no sign fix-up.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, taken naturally from the magnitude algorithm.
- Operands a, b, op are sampled only at the accepting edge; later changes have no effect.

Optional Feature:
- Macro: MDU_DIV0_FLAG_EN.
- When defined:
  - Adds output port div0 (1 bit) and sticky register div0_r.
  - Set at the FIX->IDLE edge of a div/divu with b=0.
  - Cleared by reset, or by acceptance of any new div/divu with b!=0.
  - Unaffected by mult/multu/mthi/mtlo.
- When undefined: no div0 port; port list and behaviour exactly as above.

Test Plan:
- Reset then idle: hi=0, lo=0, busy=0, done=0. Assert reset_n=0 during RUN of a mult -> busy=0 at once, hi/lo=0, no done pulse.
- mult a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Busy asserted 33 cycles; done pulses once, in the cycle hi/lo change. multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100, b=7 -> lo=0x0000000E, hi=0x00000002. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=0x1234, b=0 -> after 33 cycles hi=0x00001234, lo=0xFFFFFFFF. With MDU_DIV0_FLAG_EN, div0=1; it clears on the next divu 9/3 (lo=3, hi=0).
- Start mult 6*7, then pulse start with op=divu mid-RUN -> second op ignored, result hi=0, lo=42. Issue div 9/3 in the done cycle -> accepted; lo=3, hi=0 after 33 more cycles.
- mthi a=0xDEADBEEF, then mtlo a=0x12345678 on consecutive idle cycles -> hi/lo update at each edge, busy/done stay 0. mthi issued while busy -> ignored.

Source files
------------

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative mult/div unit holding HI/LO; MDU_DIV0_FLAG_EN adds sticky div0 output
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
`ifdef MDU_DIV0_FLAG_EN
    output logic [WIDTH-1:0] lo,
    output logic             div0
`else
    output logic [WIDTH-1:0] lo
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, is_sgn, sign_a, sign_b, b_zero;

    logic               accept, go_iter, op_sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    assign accept  = start && (state == S_IDLE);
    assign go_iter = accept && !op[2];
    assign op_sgn  = !op[0];
    assign a_mag   = (op_sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (op_sgn && b[WIDTH-1]) ? -b : b;
    assign busy    = (state != S_IDLE);

    // Multiply: acc = {partial product, remaining multiplier bits}; opnd = multiplicand
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend shifting into quotient}; opnd = divisor
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_rem   = div_ge ? (div_shift - {1'b0, opnd}) : div_shift;
    assign div_next  = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

    // With b=0 the remainder ends as |a|, so sign fix-up restores the raw dividend
    always_comb begin
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        prod   = acc;
        res_hi = '0;
        res_lo = '0;
        if (is_div) begin
            if (is_sgn && (sign_a ^ sign_b) && !b_zero)
                quo = -acc[WIDTH-1:0];
            if (is_sgn && sign_a)
                rem = -acc[2*WIDTH-1:WIDTH];
            res_hi = rem;
            res_lo = quo;
        end else begin
            if (is_sgn && (sign_a ^ sign_b))
                prod = -acc;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go_iter) state_nxt = S_RUN;
            S_RUN:   if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            is_sgn <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_iter) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        is_sgn <= op_sgn;
                        sign_a <= op_sgn && a[WIDTH-1];
                        sign_b <= op_sgn && b[WIDTH-1];
                        b_zero <= (b == '0);
                        acc    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                        opnd   <= op[1] ? b_mag : a_mag;
                    end else if (accept && op == 3'b100) begin
                        hi <= a;
                    end else if (accept && op == 3'b101) begin
                        lo <= a;
                    end
                end
                S_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div0 <= 1'b0;
        else if (state == S_FIX && is_div && b_zero)
            div0 <= 1'b1;
        else if (go_iter && op[1] && b != '0)
            div0 <= 1'b0;
    end
`endif

endmodule
